// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: datapath width,
// funct3 operation encodings, controller states and special-case constants.
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes at
// issue, a 32-step shift-add or restoring-divide loop runs through a single
// shared adder, and a final pass applies sign correction and the special
// cases (divide by zero, signed overflow) before writing back.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data
);

    muldiv_state_e     state_q, state_d;
    logic [4:0]        cnt_q;
    muldiv_op_e        op_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   aMag_q;
    logic [XLEN-1:0]   bMag_q;
    logic              aNeg_q;
    logic              bNeg_q;
    logic              divZero_q;
    logic              overflow_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   wbData_q, wbData_d;

    logic              aSignedIn, bSignedIn;
    logic              aNegIn, bNegIn;
    logic [XLEN-1:0]   aMagIn, bMagIn;
    logic              divZeroIn, overflowIn;

    logic [XLEN:0]     addA, addB;
    logic              addCin;
    logic [XLEN+1:0]   addSum;

    logic [2*XLEN-1:0] prodFix;
    logic [XLEN-1:0]   quotFix, remFix, dividendOrig;

    // Decode the incoming request into operand magnitudes and special-case flags
    always_comb begin
        aSignedIn = 1'b0;
        bSignedIn = 1'b0;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                aSignedIn = 1'b1;
                bSignedIn = 1'b1;
            end
            OP_MULHSU: aSignedIn = 1'b1;
            default: ;
        endcase
        aNegIn     = aSignedIn & rs1_val[XLEN-1];
        bNegIn     = bSignedIn & rs2_val[XLEN-1];
        aMagIn     = aNegIn ? (~rs1_val + 32'd1) : rs1_val;
        bMagIn     = bNegIn ? (~rs2_val + 32'd1) : rs2_val;
        divZeroIn  = (rs2_val == '0);
        overflowIn = (op == OP_DIV || op == OP_REM) &&
                     (rs1_val == INT_MIN) && (rs2_val == DIV0_QUOT);
    end

    // Shared adder: adds the multiplicand for multiply, subtracts the divisor for divide
    always_comb begin
        if (op_q[2]) begin
            addA   = acc_q[2*XLEN-1:XLEN-1];
            addB   = ~{1'b0, bMag_q};
            addCin = 1'b1;
        end else begin
            addA   = {1'b0, acc_q[2*XLEN-1:XLEN]};
            addB   = acc_q[0] ? {1'b0, aMag_q} : '0;
            addCin = 1'b0;
        end
        addSum = {1'b0, addA} + {1'b0, addB} + {{(XLEN+1){1'b0}}, addCin};
    end

    // One iteration step of the accumulator: shift-add for multiply, restore-or-keep for divide
    always_comb begin
        if (op_q[2]) begin
            if (addSum[XLEN+1]) begin
                acc_d = {addSum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {acc_q[2*XLEN-2:0], 1'b0};
            end
        end else begin
            acc_d = {addSum[XLEN:0], acc_q[XLEN-1:1]};
        end
    end

    // Sign correction and result selection, including the divide special cases
    always_comb begin
        prodFix      = (aNeg_q ^ bNeg_q) ? (~acc_q + 64'd1) : acc_q;
        quotFix      = (aNeg_q ^ bNeg_q) ? (~acc_q[XLEN-1:0] + 32'd1) : acc_q[XLEN-1:0];
        remFix       = aNeg_q ? (~acc_q[2*XLEN-1:XLEN] + 32'd1) : acc_q[2*XLEN-1:XLEN];
        dividendOrig = aNeg_q ? (~aMag_q + 32'd1) : aMag_q;
        wbData_d     = wbData_q;
        case (op_q)
            OP_MUL: wbData_d = prodFix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: wbData_d = prodFix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (divZero_q) begin
                    wbData_d = DIV0_QUOT;
                end else if (overflow_q) begin
                    wbData_d = INT_MIN;
                end else begin
                    wbData_d = quotFix;
                end
            end
            OP_REM, OP_REMU: begin
                if (divZero_q) begin
                    wbData_d = dividendOrig;
                end else if (overflow_q) begin
                    wbData_d = '0;
                end else begin
                    wbData_d = remFix;
                end
            end
            default: ;
        endcase
    end

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Controller next-state: flush always returns to IDLE, otherwise walk CALC -> FIX -> DONE
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) state_d = CALC;
                CALC: if (cnt_q == 5'd31) state_d = FIX;
                FIX:  state_d = DONE;
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Controller outputs derived purely from the current state
    always_comb begin
        busy  = (state_q != IDLE);
        done  = (state_q == DONE);
        wb_en = (state_q == DONE) && (rd_q != 5'd0);
    end

    // Datapath registers: capture at issue, iterate in CALC, commit the result in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            op_q       <= OP_MUL;
            rd_q       <= '0;
            aMag_q     <= '0;
            bMag_q     <= '0;
            aNeg_q     <= 1'b0;
            bNeg_q     <= 1'b0;
            divZero_q  <= 1'b0;
            overflow_q <= 1'b0;
            acc_q      <= '0;
            wbData_q   <= '0;
        end else if (!flush) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q      <= '0;
                        op_q       <= muldiv_op_e'(op);
                        rd_q       <= rd;
                        aMag_q     <= aMagIn;
                        bMag_q     <= bMagIn;
                        aNeg_q     <= aNegIn;
                        bNeg_q     <= bNegIn;
                        divZero_q  <= divZeroIn;
                        overflow_q <= overflowIn;
                        acc_q      <= op[2] ? {{XLEN{1'b0}}, aMagIn} : {{XLEN{1'b0}}, bMagIn};
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                end
                FIX: wbData_q <= wbData_d;
                default: ;
            endcase
        end
    end

    assign wb_rd   = rd_q;
    assign wb_data = wbData_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: each accepted operation pushes its
// expected write-back (from a plain-arithmetic RV32M model) with its due
// cycle, and an independent monitor checks every done pulse against it.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1Val;
    logic [31:0] rs2Val;
    logic [4:0]  rd;
    logic        flush;
    logic        busy;
    logic        done;
    logic        wbEn;
    logic [4:0]  wbRd;
    logic [31:0] wbData;

    exp_t        expQ[$];
    int          cycle;
    int          vectors;
    int          miscompares;
    logic [31:0] expWbData;

    muldiv_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs1_val (rs1Val),
        .rs2_val (rs2Val),
        .rd      (rd),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .wb_en   (wbEn),
        .wb_rd   (wbRd),
        .wb_data (wbData)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure completion latency
    always @(posedge clk) begin
        cycle <= cycle + 1;
    end

    // Reference RV32M semantics computed with 64-bit arithmetic
    function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            OP_MUL:    begin p = sa * sb; return p[31:0]; end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            OP_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic randomizeInputs();
        op     = 3'($urandom);
        rs1Val = $urandom;
        rs2Val = $urandom;
        rd     = 5'($urandom);
    endtask

    // Issue one operation, push its expectation, optionally poke start while busy
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] r, input bit pokeBusy);
        exp_t e;
        int   n;
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs1Val = a;
        rs2Val = b;
        rd     = r;
        @(posedge clk);
        #1;
        start  = 1'b0;
        e.data = refModel(o, a, b);
        e.rd   = r;
        e.due  = cycle + 33;
        expQ.push_back(e);
        expWbData = e.data;
        checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            randomizeInputs();
            start = pokeBusy && (n == 6 || n == 34);
        end while (busy && n < 40);
        start = 1'b0;
        checkOutput("idle_after_cycles", n, 35);
    endtask

    // Start an operation and abort it with flush at a chosen cycle offset
    task automatic applyFlush(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] r, input int flushAt);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs1Val = a;
        rs2Val = b;
        rd     = r;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= flushAt; n++) begin
            @(negedge clk);
            randomizeInputs();
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("busy_after_flush", {31'b0, busy}, 32'd0);
        checkOutput("wbdata_kept_after_flush", wbData, expWbData);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_done: got done=1 wb_data=%h, expected no completion", wbData);
            end else begin
                e = expQ.pop_front();
                checkOutput("wb_data", wbData, e.data);
                checkOutput("wb_rd", {27'b0, wbRd}, {27'b0, e.rd});
                checkOutput("wb_en", {31'b0, wbEn}, {31'b0, (e.rd != 5'd0)});
                checkOutput("latency", cycle, e.due);
            end
        end else if (rst_n && wbEn) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL wb_en_without_done: got wb_en=1, expected 0");
        end
    end

    // Global time limit so the run always ends
    initial begin
        #500us;
        $display("[TB] FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          pick;
        cycle       = 0;
        vectors     = 0;
        miscompares = 0;
        expWbData   = 32'd0;
        rst_n       = 1'b0;
        start       = 1'b0;
        flush       = 1'b0;
        op          = 3'd0;
        rs1Val      = 32'd0;
        rs2Val      = 32'd0;
        rd          = 5'd0;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_wb_en", {31'b0, wbEn}, 32'd0);
        checkOutput("reset_wb_rd", {27'b0, wbRd}, 32'd0);
        checkOutput("reset_wb_data", wbData, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  1'b0);
        applyStimulus(OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd1,  1'b0);
        applyStimulus(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  1'b0);
        applyStimulus(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  1'b0);
        applyStimulus(OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd4,  1'b0);
        applyStimulus(OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd6,  1'b0);
        applyStimulus(OP_DIVU,   32'd100,        32'd7,         5'd7,  1'b0);
        applyStimulus(OP_REMU,   32'd100,        32'd7,         5'd8,  1'b0);
        applyStimulus(OP_DIVU,   32'd5,          32'd0,         5'd9,  1'b0);
        applyStimulus(OP_REMU,   32'd5,          32'd0,         5'd10, 1'b0);
        applyStimulus(OP_DIV,    32'hFFFF_FFFB,  32'd0,         5'd11, 1'b0);
        applyStimulus(OP_REM,    32'hFFFF_FFFB,  32'd0,         5'd12, 1'b0);
        applyStimulus(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 1'b0);
        applyStimulus(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 1'b0);
        applyStimulus(OP_MUL,    32'd3,          32'd4,         5'd0,  1'b0);
        applyStimulus(OP_DIVU,   32'd1000,       32'd3,         5'd15, 1'b1);

        applyFlush(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5'd16, 10);
        applyStimulus(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd16, 1'b0);
        applyFlush(OP_REM, 32'hDEAD_BEEF, 32'd13, 5'd17, 33);
        applyStimulus(OP_REM, 32'hDEAD_BEEF, 32'd13, 5'd17, 1'b0);

        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flush_beats_start", {31'b0, busy}, 32'd0);
        start = 1'b0;
        flush = 1'b0;

        @(negedge clk);
        start  = 1'b1;
        op     = OP_DIV;
        rs1Val = 32'd77;
        rs2Val = 32'd5;
        rd     = 5'd18;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_op_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_mid_op_wb_data", wbData, 32'd0);
        expWbData = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 60; i++) begin
            pick = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            if (pick == 0) b = 32'd0;
            if (pick == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (pick == 2) b = 32'($urandom_range(1, 15));
            applyStimulus(3'($urandom), a, b, 5'($urandom), (pick == 3));
        end

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", expQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
